// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, constants and helpers for the data-memory
// arbiter.
//   arb_state_t : sequencer states (IDLE, RD, RMW)
//   BYTE_LANES  : byte lanes per RAM word
//   WORD_W      : RAM word width in bits
//   ADDR_BITS   : requester byte-address width
//   word_addr() : converts a byte address to a RAM word address
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RMW  = 2'd2
  } arb_state_t;

  localparam int BYTE_LANES = 4;
  localparam int WORD_W     = 8 * BYTE_LANES;
  localparam int ADDR_BITS  = 32;

  // Byte address to word address; the two lane-select bits are dropped.
  function automatic logic [ADDR_BITS-1:0] word_addr(input logic [ADDR_BITS-1:0] byte_addr);
    return {2'b00, byte_addr[ADDR_BITS-1:2]};
  endfunction

endpackage

// File: rtl/byte_merge.sv
// byte_merge: combinational lane merge used by the read-modify-write path.
//   old_word : word currently held in the RAM
//   new_word : store data from the master
//   be       : lane enables; lane k takes new_word when be[k] is set
//   merged   : resulting word to write back
module byte_merge
  import dmem_arb_pkg::*;
(
  input  logic [WORD_W-1:0]     old_word,
  input  logic [WORD_W-1:0]     new_word,
  input  logic [BYTE_LANES-1:0] be,
  output logic [WORD_W-1:0]     merged
);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < BYTE_LANES; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter and sequencer for the
// single-port data RAM (registered read, one-cycle latency, whole-word write).
// Master 0 is instruction fetch, master 1 is the load/store unit.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   mN_address                 : byte address (bits [1:0] ignored)
//   mN_read, mN_write          : request strobes (both high = write)
//   mN_byteenable              : store lane enables
//   mN_writedata               : store data
//   mN_readdata                : load data, non-zero only in the RD completion cycle
//   mN_waitrequest             : transfer not yet complete
//   mem_address                : RAM word address of the owning master
//   mem_writedata, mem_write   : RAM write word and strobe
//   mem_readdata               : RAM output, valid the cycle after the address
//   dbg_state                  : current sequencer state, for observation
//
// Handshake: a master requests by raising read or write and must hold every
// request signal stable while its waitrequest is 1. The transfer completes in
// the single cycle where request is high and waitrequest is 0; readdata is
// valid only in that cycle. The owner is locked from grant to completion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BYTE_LANES-1:0] m0_byteenable,
  input  logic [WORD_W-1:0]     m0_writedata,
  output logic [WORD_W-1:0]     m0_readdata,
  output logic                  m0_waitrequest,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BYTE_LANES-1:0] m1_byteenable,
  input  logic [WORD_W-1:0]     m1_writedata,
  output logic [WORD_W-1:0]     m1_readdata,
  output logic                  m1_waitrequest,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [WORD_W-1:0]     mem_writedata,
  output logic                  mem_write,
  input  logic [WORD_W-1:0]     mem_readdata,
  output arb_state_t            dbg_state
);

  arb_state_t state, state_next;
  logic       gnt, gnt_next;
  logic       last, last_next;

  logic req0, req1, any_req, idle_pick, owner;
  logic [ADDR_W-1:0]     own_addr;
  logic                  own_write;
  logic [BYTE_LANES-1:0] own_be;
  logic [WORD_W-1:0]     own_wdata;
  logic [WORD_W-1:0]     merged;
  logic                  done, rd_done;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign any_req = req0 | req1;

  // On a tie the master that was not served last wins; otherwise whichever
  // master is requesting (defaults to 0 when idle, harmless since unused).
  assign idle_pick = (req0 && req1) ? ~last : req1;

  // In IDLE the master being granted this cycle drives the RAM; afterwards
  // the locked grant does.
  assign owner     = (state == IDLE) ? idle_pick : gnt;
  assign own_addr  = owner ? m1_address    : m0_address;
  assign own_write = owner ? m1_write      : m0_write;
  assign own_be    = owner ? m1_byteenable : m0_byteenable;
  assign own_wdata = owner ? m1_writedata  : m0_writedata;

  assign dbg_state = state;

  byte_merge u_merge (
    .old_word (mem_readdata),
    .new_word (own_wdata),
    .be       (own_be),
    .merged   (merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      last  <= last_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    last_next  = last;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_next  = idle_pick;
          last_next = idle_pick;
          if (!own_write)
            state_next = RD;
          else if (own_be != '1 && own_be != '0)
            state_next = RMW;
        end
      end
      RD:      state_next = IDLE;
      RMW:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic. Everything is held at zero while reset is high, which also
  // suppresses the write strobe of an interrupted read-modify-write.
  always_comb begin
    mem_address   = '0;
    mem_writedata = '0;
    mem_write     = 1'b0;
    done          = 1'b0;
    rd_done       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_address = word_addr(own_addr);
            if (own_write) begin
              if (own_be == '1) begin
                mem_write     = 1'b1;
                mem_writedata = own_wdata;
                done          = 1'b1;
              end else if (own_be == '0) begin
                done = 1'b1;
              end
            end
          end
        end
        RD: begin
          mem_address = word_addr(own_addr);
          done        = 1'b1;
          rd_done     = 1'b1;
        end
        RMW: begin
          mem_address   = word_addr(own_addr);
          mem_write     = 1'b1;
          mem_writedata = merged;
          done          = 1'b1;
        end
        default: ;
      endcase
    end
    m0_readdata    = (rd_done && !owner) ? mem_readdata : '0;
    m1_readdata    = (rd_done &&  owner) ? mem_readdata : '0;
    m0_waitrequest = req0 && !(done && !owner);
    m1_waitrequest = req1 && !(done &&  owner);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m1_read, m0_write, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_write;
  arb_state_t  dbg_state;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_readdata(mem_readdata),
    .dbg_state(dbg_state)
  );

  // RAM environment: registered read, whole-word write.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_write) ram[mem_address[9:0]] <= mem_writedata;
    mem_readdata <= ram[mem_address[9:0]];
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];      // expected readdata, pushed at drive time
  logic [63:0] exp_wr_q[$];   // expected {word address, data} RAM writes
  logic [63:0] wr_exp;
  logic [31:0] rd_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every RAM write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 mem_address, mem_writedata);
      end else begin
        wr_exp = exp_wr_q.pop_front();
        check("mem_write_word", {mem_address, mem_writedata}, wr_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask

  typedef struct {
    logic        master;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        exp_mw;    // a RAM write is expected
    logic [31:0] exp_data;  // readdata for reads, written word for writes
    int          exp_lat;   // cycles from grant to completion, inclusive
  } txn_t;

  task automatic run_txn(input txn_t t, input string name);
    int lat;
    logic ok;
    @(posedge clk); #1;
    idle_all();
    if (t.master) begin
      m1_read = t.rd; m1_write = t.wr; m1_address = t.addr;
      m1_byteenable = t.be; m1_writedata = t.wdata;
    end else begin
      m0_read = t.rd; m0_write = t.wr; m0_address = t.addr;
      m0_byteenable = t.be; m0_writedata = t.wdata;
    end
    if (!t.wr) exp_q.push_back(t.exp_data);
    if (t.exp_mw) exp_wr_q.push_back({t.addr >> 2, t.exp_data});
    ok = 0;
    lat = 0;
    for (int c = 1; c <= 10 && !ok; c++) begin
      @(negedge clk);
      check({name, "_other_rdata"}, t.master ? m0_readdata : m1_readdata, 32'h0);
      if ((t.master ? m1_waitrequest : m0_waitrequest) == 1'b0) begin
        ok = 1;
        lat = c;
        if (!t.wr) begin
          rd_exp = exp_q.pop_front();
          check({name, "_rdata"}, t.master ? m1_readdata : m0_readdata, rd_exp);
        end
      end else begin
        check({name, "_rdata_wait"}, t.master ? m1_readdata : m0_readdata, 32'h0);
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no completion expected %0d cycles", name, t.exp_lat);
      if (!t.wr) void'(exp_q.pop_front());
    end else begin
      check({name, "_latency"}, lat, t.exp_lat);
    end
    @(posedge clk); #1;
    idle_all();
  endtask

  // ---------------- test ----------------
  txn_t tbl [11];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h40, 4'b0101, 32'h11223344, 1'b1, 32'hAA22CC44, 2};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h40, 4'b0000, 32'h0,        1'b0, 32'hAA22CC44, 2};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h40, 4'b1111, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 32'h40, 4'b0000, 32'h0,        1'b0, 32'hCAFEF00D, 2};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h44, 4'b0000, 32'hFFFFFFFF, 1'b0, 32'h0,        1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'h44, 4'b0000, 32'h0,        1'b0, 32'h12345678, 2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h80, 4'b1000, 32'h99000000, 1'b1, 32'h99020304, 2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h81, 4'b0010, 32'h0000AB00, 1'b1, 32'h9902AB04, 2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h83, 4'b0000, 32'h0,        1'b0, 32'h9902AB04, 2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h84, 4'b1111, 32'h5555AAAA, 1'b1, 32'h5555AAAA, 1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h84, 4'b0000, 32'h0,        1'b0, 32'h5555AAAA, 2};

    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[10'h10] = 32'hAABBCCDD;
    ram[10'h11] = 32'h12345678;
    ram[10'h20] = 32'h01020304;

    // Reset values, with both masters requesting during reset.
    idle_all();
    reset = 1;
    m0_read = 1; m0_address = 32'h44;
    m1_write = 1; m1_address = 32'h80; m1_byteenable = 4'hF; m1_writedata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_write", mem_write, 1'b0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_writedata", mem_writedata, 32'h0);
    check("rst_m0_rdata", m0_readdata, 32'h0);
    check("rst_m1_rdata", m1_readdata, 32'h0);
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    idle_all();
    reset = 0;

    // Tie-break: m0 first, then a repeated tie serves m1 first.
    @(posedge clk); #1;
    m0_read = 1; m0_address = 32'h44;
    m1_read = 1; m1_address = 32'h80;
    @(negedge clk);
    check("tie_c0_addr", mem_address, 32'h11);
    check("tie_c0_m0_wait", m0_waitrequest, 1'b1);
    check("tie_c0_m1_wait", m1_waitrequest, 1'b1);
    @(negedge clk);
    check("tie_c1_m0_wait", m0_waitrequest, 1'b0);
    check("tie_c1_m0_rdata", m0_readdata, 32'h12345678);
    check("tie_c1_m1_wait", m1_waitrequest, 1'b1);
    check("tie_c1_m1_rdata", m1_readdata, 32'h0);
    @(posedge clk); #1;
    m0_address = 32'h40;                       // m0 re-requests immediately
    @(negedge clk);
    check("tie_c2_addr", mem_address, 32'h20);
    check("tie_c2_m0_wait", m0_waitrequest, 1'b1);
    check("tie_c2_m1_wait", m1_waitrequest, 1'b1);
    @(negedge clk);
    check("tie_c3_m1_wait", m1_waitrequest, 1'b0);
    check("tie_c3_m1_rdata", m1_readdata, 32'h01020304);
    check("tie_c3_m0_wait", m0_waitrequest, 1'b1);
    @(posedge clk); #1;
    m1_read = 0; m1_address = '0;
    @(negedge clk);
    check("tie_c4_addr", mem_address, 32'h10);
    @(negedge clk);
    check("tie_c5_m0_wait", m0_waitrequest, 1'b0);
    check("tie_c5_m0_rdata", m0_readdata, 32'hAABBCCDD);
    @(posedge clk); #1;
    idle_all();

    // Table-driven transactions.
    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Write throughput: four full writes from m1 on consecutive cycles.
    for (int i = 0; i < 4; i++) exp_wr_q.push_back({32'h40 + i, 32'(i)});
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      m1_write = 1; m1_byteenable = 4'hF;
      m1_address = 32'h100 + 32'(4 * i); m1_writedata = 32'(i);
      @(negedge clk);
      check("thru_wait", m1_waitrequest, 1'b0);
      check("thru_strobe", mem_write, 1'b1);
      @(posedge clk); #1;
    end
    idle_all();

    // Reset asserted in the RMW cycle: no write, IDLE afterwards, RAM intact.
    @(posedge clk); #1;
    m1_write = 1; m1_address = 32'h80; m1_byteenable = 4'b0011; m1_writedata = 32'hFFFFFFFF;
    @(negedge clk);
    check("rstrmw_c0_wait", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    check("rstrmw_c1_strobe", mem_write, 1'b0);
    check("rstrmw_c1_wait", m1_waitrequest, 1'b1);
    @(posedge clk); #1;
    reset = 0;
    idle_all();
    @(negedge clk);
    check("rstrmw_state", dbg_state, IDLE);
    run_txn('{1'b0, 1'b1, 1'b0, 32'h80, 4'b0000, 32'h0, 1'b0, 32'h9902AB04, 2}, "rstrmw_readback");

    repeat (2) @(posedge clk);
    check("exp_wr_q_empty", exp_wr_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
